core_pipe_stage: RTL and testbench

Parametrised inter-stage pipeline buffer for the core pipeline: a DEPTH-entry in-order queue with valid/ready handshake on both sides, synchronous flush and a defined bubble value on the output. It replaces fixed write-enable-plus-flush stage registers (IF/ID, ID/EX, …) so that any stage boundary can absorb backpressure without losing instructions. The upstream stage pushes `{pc_plus_4, inst_word}` or any other payload; the downstream stage pops it.

---
 rtl/core_pipe_stage_if.sv | 27 ++
 rtl/core_pipe_stage.sv | 65 ++++++
 tb/tb_core_pipe_stage.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/core_pipe_stage_if.sv
// Handshake bundle between an upstream stage, the pipeline buffer and the downstream stage.
// The buffer takes the slave view; the surrounding pipeline (or a bench) takes the master view.
interface core_pipe_stage_if #(
   parameter int DW    = 64,
   parameter int DEPTH = 2
);
   localparam int CW = $clog2(DEPTH) + 1;

   logic          in_valid;
   logic          in_ready;
   logic [DW-1:0] in_data;
   logic          out_valid;
   logic          out_ready;
   logic [DW-1:0] out_data;
   logic          flush;
   logic [CW-1:0] count;

   modport slave (
      input  in_valid, in_data, out_ready, flush,
      output in_ready, out_valid, out_data, count
   );

   modport master (
      output in_valid, in_data, out_ready, flush,
      input  in_ready, out_valid, out_data, count
   );
endinterface

// File: rtl/core_pipe_stage.sv
// In-order DEPTH-entry pipeline buffer with valid/ready on both sides, synchronous flush
// and a fixed bubble value on the output whenever the buffer is empty.
module core_pipe_stage #(
   parameter int            DW     = 64,
   parameter int            DEPTH  = 2,
   parameter logic [DW-1:0] BUBBLE = '0
) (
   input  logic              clk,
   input  logic              rst,
   core_pipe_stage_if.slave  bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;

   logic [PW-1:0] rp_q, rp_d;
   logic [PW-1:0] wp_q, wp_d;
   logic [DW-1:0] mem_q [DEPTH];

   logic          empty;
   logic          full;
   logic          push;
   logic          pop;
   logic [AW-1:0] rp_idx;
   logic [AW-1:0] wp_idx;

   assign rp_idx = rp_q[AW-1:0];
   assign wp_idx = wp_q[AW-1:0];

   // Extra pointer bit distinguishes full from empty when the indices coincide.
   always_comb begin
      empty = (rp_q == wp_q);
      full  = (rp_idx == wp_idx) && (rp_q[AW] != wp_q[AW]);
      push  = bus.in_valid & ~full & ~bus.flush;
      pop   = bus.out_ready & ~empty & ~bus.flush;
      rp_d  = rp_q;
      wp_d  = wp_q;
      if (bus.flush) begin
         rp_d = '0;
         wp_d = '0;
      end else begin
         if (push) wp_d = wp_q + PW'(1);
         if (pop)  rp_d = rp_q + PW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rp_q <= '0;
         wp_q <= '0;
      end else begin
         rp_q <= rp_d;
         wp_q <= wp_d;
      end
   end

   // Payload storage is never reset; only the pointers define what is valid.
   always_ff @(posedge clk) begin
      if (push) mem_q[wp_idx] <= bus.in_data;
   end

   assign bus.in_ready  = ~full;
   assign bus.out_valid = ~empty;
   assign bus.out_data  = empty ? BUBBLE : mem_q[rp_idx];
   assign bus.count     = wp_q - rp_q;
endmodule

// File: tb/tb_core_pipe_stage.sv
// Randomised and directed bench for core_pipe_stage against a queue-based reference model.
module tb_core_pipe_stage;
   localparam int DW    = 64;
   localparam int DEPTH = 4;
   localparam int CW    = $clog2(DEPTH) + 1;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   core_pipe_stage_if #(.DW(DW), .DEPTH(DEPTH)) bus ();

   core_pipe_stage #(.DW(DW), .DEPTH(DEPTH), .BUBBLE(64'h0)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int checks = 0;
   int passes = 0;

   logic [DW-1:0] model_q [$];
   bit            hold_pending = 0;
   logic [DW-1:0] held_data;

   // One clock: check upstream stability, advance the model, settle 1 time unit past the edge.
   task automatic cycle();
      int sz;
      bit acc;
      bit pp;
      @(posedge clk);
      if (hold_pending && rst) begin
         checks++;
         if (bus.in_valid !== 1'b1 || bus.in_data !== held_data)
            $display("FAIL upstream_hold: valid=%0b data=%0h required valid=1 data=%0h",
                     bus.in_valid, bus.in_data, held_data);
         else passes++;
      end
      sz  = model_q.size();
      acc = bus.in_valid && (sz < DEPTH) && !bus.flush;
      pp  = bus.out_ready && (sz > 0) && !bus.flush;
      if (!rst || bus.flush) begin
         model_q.delete();
      end else begin
         if (pp)  void'(model_q.pop_front());
         if (acc) model_q.push_back(bus.in_data);
      end
      hold_pending = rst && bus.in_valid && !acc && !bus.flush;
      held_data    = bus.in_data;
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      bus.in_valid = 0; bus.in_data = '0; bus.out_ready = 0; bus.flush = 0;
      for (int i = 0; i < 6; i++) begin
         if (i == 3) rst = 1'b1;
         cycle();
         checks++;
         if (bus.out_valid !== 1'b0 || bus.out_data !== 64'h0 || bus.in_ready !== 1'b1 || bus.count !== CW'(0))
            $display("FAIL reset_idle: valid=%0b data=%0h ready=%0b count=%0d required 0/0/1/0",
                     bus.out_valid, bus.out_data, bus.in_ready, bus.count);
         else passes++;
      end
      $display("test_reset: idle outputs checked over 6 cycles");
   endtask

   task automatic test_single();
      bus.in_valid = 1; bus.in_data = 64'h0000_0004_2402_0001; bus.out_ready = 0;
      cycle();
      bus.in_valid = 0;
      for (int i = 0; i < 2; i++) begin
         checks++;
         if (bus.out_valid !== 1'b1 || bus.out_data !== 64'h0000_0004_2402_0001 || bus.count !== CW'(1))
            $display("FAIL single_hold: valid=%0b data=%0h count=%0d required 1/0000000424020001/1",
                     bus.out_valid, bus.out_data, bus.count);
         else passes++;
         cycle();
      end
      bus.out_ready = 1;
      cycle();
      bus.out_ready = 0;
      checks++;
      if (bus.out_valid !== 1'b0 || bus.out_data !== 64'h0)
         $display("FAIL single_pop: valid=%0b data=%0h required 0/0", bus.out_valid, bus.out_data);
      else passes++;
      $display("test_single: payload 0000000424020001 transferred");
   endtask

   task automatic test_fill();
      logic [DW-1:0] got [$];
      bit acc;
      bus.out_ready = 0;
      for (int i = 1; i <= 4; i++) begin
         bus.in_valid = 1; bus.in_data = DW'(i);
         cycle();
      end
      bus.in_data = 64'd5;
      checks++;
      if (bus.count !== CW'(4) || bus.in_ready !== 1'b0)
         $display("FAIL fill_full: count=%0d ready=%0b required 4/0", bus.count, bus.in_ready);
      else passes++;
      cycle(); cycle();
      checks++;
      if (bus.count !== CW'(4))
         $display("FAIL fill_hold5: count=%0d required 4", bus.count);
      else passes++;
      bus.out_ready = 1;
      for (int k = 0; k < 12; k++) begin
         if (bus.out_valid) got.push_back(bus.out_data);
         acc = bus.in_valid && bus.in_ready;
         cycle();
         if (acc) bus.in_valid = 0;
         if (k == 0) begin
            checks++;
            if (bus.in_ready !== 1'b1)
               $display("FAIL fill_reopen: in_ready=%0b required 1", bus.in_ready);
            else passes++;
         end
         if (got.size() >= 5 && !bus.out_valid) break;
      end
      bus.out_ready = 0; bus.in_valid = 0;
      checks++;
      if (got.size() != 5)
         $display("FAIL fill_drain_count: got %0d payloads required 5", got.size());
      else passes++;
      for (int i = 0; i < got.size() && i < 5; i++) begin
         checks++;
         if (got[i] !== DW'(i + 1))
            $display("FAIL fill_order[%0d]: %0h required %0h", i, got[i], i + 1);
         else passes++;
      end
      $display("test_fill: drained %0d payloads", got.size());
   endtask

   task automatic test_stream();
      int bad = 0;
      bus.out_ready = 1;
      for (int i = 0; i < 40; i++) begin
         bus.in_valid = 1; bus.in_data = DW'(i);
         cycle();
         checks++;
         if (bus.out_valid !== 1'b1 || bus.out_data !== DW'(i) || bus.count !== CW'(1)) begin
            $display("FAIL stream[%0d]: valid=%0b data=%0h count=%0d required 1/%0h/1",
                     i, bus.out_valid, bus.out_data, bus.count, i);
            bad++;
         end else passes++;
      end
      bus.in_valid = 0;
      cycle();
      bus.out_ready = 0;
      checks++;
      if (bus.out_valid !== 1'b0 || bus.count !== CW'(0))
         $display("FAIL stream_drain: valid=%0b count=%0d required 0/0", bus.out_valid, bus.count);
      else passes++;
      $display("test_stream: 40 payloads streamed, %0d bad", bad);
   endtask

   task automatic test_flush();
      bus.out_ready = 0;
      for (int i = 0; i < 3; i++) begin
         bus.in_valid = 1; bus.in_data = DW'(8'h10 + i);
         cycle();
      end
      checks++;
      if (bus.count !== CW'(3))
         $display("FAIL flush_pre: count=%0d required 3", bus.count);
      else passes++;
      bus.flush = 1; bus.in_valid = 1; bus.in_data = 64'hAA; bus.out_ready = 1;
      cycle();
      bus.flush = 0; bus.in_valid = 0; bus.out_ready = 0;
      checks++;
      if (bus.count !== CW'(0) || bus.out_valid !== 1'b0 || bus.out_data !== 64'h0 || bus.in_ready !== 1'b1)
         $display("FAIL flush_clear: count=%0d valid=%0b data=%0h ready=%0b required 0/0/0/1",
                  bus.count, bus.out_valid, bus.out_data, bus.in_ready);
      else passes++;
      for (int i = 0; i < 3; i++) begin
         cycle();
         checks++;
         if (bus.out_valid !== 1'b0 || bus.out_data === 64'hAA)
            $display("FAIL flush_stale: valid=%0b data=%0h required 0/0", bus.out_valid, bus.out_data);
         else passes++;
      end
      $display("test_flush: collision flush discarded 3 entries and dropped AA");
   endtask

   task automatic test_async_reset();
      bus.out_ready = 0;
      for (int i = 0; i < 2; i++) begin
         bus.in_valid = 1; bus.in_data = DW'(8'h21 + i);
         cycle();
      end
      bus.in_valid = 0;
      checks++;
      if (bus.count !== CW'(2))
         $display("FAIL areset_pre: count=%0d required 2", bus.count);
      else passes++;
      #3 rst = 1'b0;
      #1;
      model_q.delete();
      hold_pending = 0;
      checks++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.count !== CW'(0) || bus.out_data !== 64'h0)
         $display("FAIL areset_immediate: valid=%0b ready=%0b count=%0d data=%0h required 0/1/0/0",
                  bus.out_valid, bus.in_ready, bus.count, bus.out_data);
      else passes++;
      cycle();
      rst = 1'b1;
      bus.in_valid = 1; bus.in_data = 64'h33;
      cycle();
      bus.in_valid = 0;
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== 64'h33 || bus.count !== CW'(1))
         $display("FAIL areset_first: valid=%0b data=%0h count=%0d required 1/33/1",
                  bus.out_valid, bus.out_data, bus.count);
      else passes++;
      bus.out_ready = 1;
      cycle();
      bus.out_ready = 0;
      checks++;
      if (bus.out_valid !== 1'b0 || bus.count !== CW'(0))
         $display("FAIL areset_nostale: valid=%0b count=%0d required 0/0", bus.out_valid, bus.count);
      else passes++;
      $display("test_async_reset: mid-stream reset cleared 2 entries");
   endtask

   task automatic test_random();
      int bad = 0;
      logic [CW-1:0] exp_count;
      logic [DW-1:0] exp_data;
      for (int i = 0; i < 400; i++) begin
         if (!hold_pending) begin
            bus.in_valid = ($urandom_range(9, 0) < 7);
            bus.in_data  = {$urandom, $urandom};
         end
         bus.out_ready = ($urandom_range(9, 0) < 6);
         bus.flush     = ($urandom_range(15, 0) == 0);
         cycle();
         exp_count = CW'(model_q.size());
         exp_data  = (model_q.size() > 0) ? model_q[0] : 64'h0;
         checks++;
         if (bus.count !== exp_count || bus.out_valid !== (model_q.size() > 0) ||
             bus.in_ready !== (model_q.size() < DEPTH) || bus.out_data !== exp_data) begin
            $display("FAIL random[%0d]: count=%0d valid=%0b ready=%0b data=%0h required %0d/%0b/%0b/%0h",
                     i, bus.count, bus.out_valid, bus.in_ready, bus.out_data, exp_count,
                     model_q.size() > 0, model_q.size() < DEPTH, exp_data);
            bad++;
         end else passes++;
      end
      bus.in_valid = 0; bus.out_ready = 0; bus.flush = 0;
      $display("test_random: 400 cycles, %0d bad", bad);
   endtask

   initial begin
      test_reset();
      test_single();
      test_fill();
      test_stream();
      test_flush();
      test_async_reset();
      test_random();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, required completion");
      $fatal(1);
   end
endmodule
